// File: rtl/ysyx_22041207_shift_mul_if.sv
// Request/response bundle between the ALU (master) and the iterative shift-add multiplier (slave).
interface ysyx_22041207_shift_mul_if;
  logic        mul_valid;
  logic        flush;
  logic [63:0] multiplicand;
  logic [63:0] multiplier;
  logic        mulw;
  logic [1:0]  mul_signed;
  logic        mul_ready;
  logic        out_valid;
  logic [63:0] result_hi;
  logic [63:0] result_lo;

  modport master (
    output mul_valid, flush, multiplicand, multiplier, mulw, mul_signed,
    input  mul_ready, out_valid, result_hi, result_lo
  );

  modport slave (
    input  mul_valid, flush, multiplicand, multiplier, mulw, mul_signed,
    output mul_ready, out_valid, result_hi, result_lo
  );
endinterface

// File: rtl/ysyx_22041207_shift_mul.sv
// Radix-2 shift-add 64x64->128 multiplier with RV64M signedness, MULW and flush abort.
// Optional feature: define YSYX_22041207_MUL_EARLY_EXIT_EN to finish once the remaining multiplier is zero.
module ysyx_22041207_shift_mul (
  input  logic                            clk,
  input  logic                            rst,
  ysyx_22041207_shift_mul_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_r;
  logic [127:0] mcand_r;
  logic [63:0]  mplier_r;
  logic [127:0] acc_r;
  logic [6:0]   cnt_r;
  logic         neg_r;
  logic         mulw_r;
  logic         ready_r;
  logic         valid_r;
  logic [63:0]  res_hi_r;
  logic [63:0]  res_lo_r;

  logic [63:0]  abs_a_s;
  logic [63:0]  abs_b_s;
  logic         neg_s;
  logic [6:0]   steps_s;
  logic [127:0] acc_step_s;
  logic [63:0]  mplier_next_s;
  logic [127:0] product_s;
  logic         last_step_s;
  logic [63:0]  res_hi_next_s;
  logic [63:0]  res_lo_next_s;

  function automatic logic [63:0] magnitude(input logic [63:0] v, input logic is_signed);
    if (is_signed && v[63]) begin
      magnitude = ~v + 64'd1;
    end else begin
      magnitude = v;
    end
  endfunction

  // Operand preparation at acceptance; MULW keeps only the low word, whose product bits are sign-independent.
  always_comb begin
    abs_a_s = 64'd0;
    abs_b_s = 64'd0;
    neg_s   = 1'b0;
    steps_s = 7'd64;
    if (bus.mulw) begin
      abs_a_s = {32'd0, bus.multiplicand[31:0]};
      abs_b_s = {32'd0, bus.multiplier[31:0]};
      neg_s   = 1'b0;
      steps_s = 7'd32;
    end else begin
      abs_a_s = magnitude(bus.multiplicand, bus.mul_signed[1]);
      abs_b_s = magnitude(bus.multiplier, bus.mul_signed[1] & bus.mul_signed[0]);
      neg_s   = (bus.multiplicand[63] & bus.mul_signed[1]) ^
                (bus.multiplier[63] & bus.mul_signed[1] & bus.mul_signed[0]);
      steps_s = 7'd64;
    end
  end

  // One shift-add step plus the sign-corrected, width-formatted result for the final step.
  always_comb begin
    acc_step_s    = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
    mplier_next_s = {1'b0, mplier_r[63:1]};
    product_s     = neg_r ? (~acc_step_s + 128'd1) : acc_step_s;
`ifdef YSYX_22041207_MUL_EARLY_EXIT_EN
    last_step_s   = (cnt_r == 7'd1) || (mplier_next_s == 64'd0);
`else
    last_step_s   = (cnt_r == 7'd1);
`endif
    if (mulw_r) begin
      res_hi_next_s = 64'd0;
      res_lo_next_s = {{32{product_s[31]}}, product_s[31:0]};
    end else begin
      res_hi_next_s = product_s[127:64];
      res_lo_next_s = product_s[63:0];
    end
  end

  // Control FSM and datapath registers; reset beats flush, flush beats accept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= IDLE;
      mcand_r  <= 128'd0;
      mplier_r <= 64'd0;
      acc_r    <= 128'd0;
      cnt_r    <= 7'd0;
      neg_r    <= 1'b0;
      mulw_r   <= 1'b0;
      ready_r  <= 1'b1;
      valid_r  <= 1'b0;
      res_hi_r <= 64'd0;
      res_lo_r <= 64'd0;
    end else if (bus.flush) begin
      state_r <= IDLE;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.mul_valid) begin
            mcand_r  <= {64'd0, abs_a_s};
            mplier_r <= abs_b_s;
            acc_r    <= 128'd0;
            cnt_r    <= steps_s;
            neg_r    <= neg_s;
            mulw_r   <= bus.mulw;
            state_r  <= BUSY;
            ready_r  <= 1'b0;
            valid_r  <= 1'b0;
          end else begin
            ready_r  <= 1'b1;
            valid_r  <= 1'b0;
          end
        end
        BUSY: begin
          acc_r    <= acc_step_s;
          mcand_r  <= {mcand_r[126:0], 1'b0};
          mplier_r <= mplier_next_s;
          cnt_r    <= cnt_r - 7'd1;
          if (last_step_s) begin
            res_hi_r <= res_hi_next_s;
            res_lo_r <= res_lo_next_s;
            state_r  <= DONE;
            valid_r  <= 1'b1;
          end else begin
            valid_r  <= 1'b0;
          end
        end
        DONE: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.mul_ready = ready_r;
  assign bus.out_valid = valid_r;
  assign bus.result_hi = res_hi_r;
  assign bus.result_lo = res_lo_r;

endmodule

// File: tb/tb_ysyx_22041207_shift_mul.sv
// Self-checking bench for ysyx_22041207_shift_mul: fixed vectors, flush/reset sequences, random ops vs. arithmetic model.
module tb_ysyx_22041207_shift_mul;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  ysyx_22041207_shift_mul_if bus ();

  ysyx_22041207_shift_mul dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  sg;
    logic        w;
    logic [63:0] hi;
    logic [63:0] lo;
  } vec_t;

  vec_t tbl [10];

  // Full-precision product from the signedness rules using plain 128-bit arithmetic.
  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                           input logic [1:0] sg, input logic w);
    logic [127:0] ax;
    logic [127:0] bx;
    logic [63:0]  pw;
    if (w) begin
      pw = {32'd0, a[31:0]} * {32'd0, b[31:0]};
      ref_mul = {64'd0, {32{pw[31]}}, pw[31:0]};
    end else begin
      ax = sg[1] ? {{64{a[63]}}, a} : {64'd0, a};
      bx = (sg == 2'b11) ? {{64{b[63]}}, b} : {64'd0, b};
      ref_mul = ax * bx;
    end
  endfunction

  // Expected number of step edges; 0 means "any value in 1..32".
  function automatic int ref_steps(input logic [63:0] b, input logic [1:0] sg, input logic w);
`ifdef YSYX_22041207_MUL_EARLY_EXIT_EN
    logic [63:0] m;
    int h;
    if (w) return 0;
    m = (sg == 2'b11 && b[63]) ? (~b + 64'd1) : b;
    if (m == 64'd0) return 1;
    h = 0;
    for (int i = 0; i < 64; i++) if (m[i]) h = i;
    return h + 1;
`else
    return w ? 32 : 64;
`endif
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_steps(input string name, input int got, input int exp);
    n_vec++;
    if ((exp == 0 && (got < 1 || got > 32)) || (exp != 0 && got != exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d steps expected %0d (0 = 1..32)", name, got, exp);
    end
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] sg,
                        input logic w, output logic [63:0] hi, output logic [63:0] lo,
                        output int steps);
    @(negedge clk);
    bus.mul_valid    = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.mul_signed   = sg;
    bus.mulw         = w;
    @(negedge clk);
    bus.mul_valid    = 1'b0;
    bus.multiplicand = {$urandom, $urandom};
    bus.multiplier   = {$urandom, $urandom};
    bus.mul_signed   = 2'($urandom_range(0, 3));
    bus.mulw         = 1'($urandom_range(0, 1));
    check("ready_low_busy", {127'd0, bus.mul_ready}, 128'd0);
    steps = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        steps = k;
        break;
      end
    end
    hi = bus.result_hi;
    lo = bus.result_lo;
    if (steps > 0) begin
      @(negedge clk);
      check("valid_one_cycle", {127'd0, bus.out_valid}, 128'd0);
      check("ready_after_done", {127'd0, bus.mul_ready}, 128'd1);
    end
  endtask

  task automatic watch_no_valid(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check(name, {127'd0, seen}, 128'd0);
  endtask

  initial begin
    logic [63:0]  hi;
    logic [63:0]  lo;
    logic [63:0]  last_hi;
    logic [63:0]  last_lo;
    logic [127:0] exp_p;
    logic [63:0]  a;
    logic [63:0]  b;
    logic [1:0]   sg;
    logic         w;
    int           steps;

    n_vec = 0;
    n_bad = 0;
    tbl[0] = '{64'd3, 64'd5, 2'b00, 1'b0, 64'd0, 64'd15};
    tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFA};
    tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1};
    tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
    tbl[4] = '{64'h0000_0000_7FFF_FFFF, 64'd2, 2'b00, 1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE};
    tbl[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1};
    tbl[6] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b11, 1'b0, 64'h4000_0000_0000_0000, 64'd0};
    tbl[7] = '{64'd0, 64'd12345, 2'b00, 1'b0, 64'd0, 64'd0};
    tbl[8] = '{64'hDEAD_BEEF_FFFF_FFFF, 64'h1234_5678_FFFF_FFFF, 2'b11, 1'b1, 64'd0, 64'd1};
    tbl[9] = '{64'd7, 64'd6, 2'b00, 1'b0, 64'd0, 64'd42};

    rst              = 1'b0;
    bus.mul_valid    = 1'b0;
    bus.flush        = 1'b0;
    bus.multiplicand = 64'd0;
    bus.multiplier   = 64'd0;
    bus.mulw         = 1'b0;
    bus.mul_signed   = 2'b00;
    repeat (3) @(negedge clk);
    check("reset_ready", {127'd0, bus.mul_ready}, 128'd1);
    check("reset_valid", {127'd0, bus.out_valid}, 128'd0);
    check("reset_result", {bus.result_hi, bus.result_lo}, 128'd0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].sg, tbl[i].w, hi, lo, steps);
      check($sformatf("vec%0d_result", i), {hi, lo}, {tbl[i].hi, tbl[i].lo});
      check_steps($sformatf("vec%0d_latency", i), steps, ref_steps(tbl[i].b, tbl[i].sg, tbl[i].w));
      last_hi = hi;
      last_lo = lo;
    end

    // Flush at E10 of a full-length operation.
    @(negedge clk);
    bus.mul_valid    = 1'b1;
    bus.multiplicand = 64'h0123_4567_89AB_CDEF;
    bus.multiplier   = 64'h8000_0000_0000_0001;
    bus.mul_signed   = 2'b00;
    bus.mulw         = 1'b0;
    @(negedge clk);
    bus.mul_valid = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_valid", {127'd0, bus.out_valid}, 128'd0);
    check("flush_ready", {127'd0, bus.mul_ready}, 128'd1);
    check("flush_result_held", {bus.result_hi, bus.result_lo}, {last_hi, last_lo});
    watch_no_valid("flush_no_valid", 80);

    // Flush together with a request in IDLE.
    @(negedge clk);
    bus.mul_valid = 1'b1;
    bus.flush     = 1'b1;
    @(negedge clk);
    bus.mul_valid = 1'b0;
    bus.flush     = 1'b0;
    check("flush_accept_ready", {127'd0, bus.mul_ready}, 128'd1);
    watch_no_valid("flush_accept_no_valid", 80);

    // Reset at E20 of an operation, then a fresh request.
    @(negedge clk);
    bus.mul_valid    = 1'b1;
    bus.multiplicand = 64'hFFFF_0000_FFFF_0000;
    bus.multiplier   = 64'h8000_0000_0000_0003;
    @(negedge clk);
    bus.mul_valid = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midop_reset_ready", {127'd0, bus.mul_ready}, 128'd1);
    check("midop_reset_valid", {127'd0, bus.out_valid}, 128'd0);
    check("midop_reset_result", {bus.result_hi, bus.result_lo}, 128'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_no_stale_valid", {127'd0, bus.out_valid}, 128'd0);
    run_op(64'd7, 64'd6, 2'b00, 1'b0, hi, lo, steps);
    check("post_reset_7x6", {hi, lo}, {64'd0, 64'd42});
    check_steps("post_reset_latency", steps, ref_steps(64'd6, 2'b00, 1'b0));

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      a  = {$urandom, $urandom};
      b  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 300)) : {$urandom, $urandom};
      sg = 2'($urandom_range(0, 3));
      w  = ($urandom_range(0, 3) == 0);
      exp_p = ref_mul(a, b, sg, w);
      run_op(a, b, sg, w, hi, lo, steps);
      check($sformatf("rand%0d_result", i), {hi, lo}, exp_p);
      check_steps($sformatf("rand%0d_latency", i), steps, ref_steps(b, sg, w));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
